// File: rtl/sm83_pkg.sv
// Shared SM83 types plus the DIV/TIMA/TMA/TAC timer definitions.
// Bus word types are common to every responder on the core bus.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam logic [1:0] TMR_DIV  = 2'd0;
    localparam logic [1:0] TMR_TIMA = 2'd1;
    localparam logic [1:0] TMR_TMA  = 2'd2;
    localparam logic [1:0] TMR_TAC  = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } tmr_state_t;

    function automatic logic [3:0] tac_bit(input logic [1:0] sel);
        logic [3:0] b;
        unique case (sel)
            2'b00:   b = 4'd9;
            2'b01:   b = 4'd3;
            2'b10:   b = 4'd5;
            2'b11:   b = 4'd7;
            default: b = 4'd9;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sm83_timer_tick.sv
// Free-running system counter, TAC tap select and falling-edge
// detector that produces the TIMA increment strobe.
module sm83_timer_tick
    import sm83_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       div_clr_i,
    input  logic [2:0] tac_i,
    output data_t      div_o,
    output logic       inc_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        prev_q;
    logic        tick;

    always_comb begin
        cnt_d = div_clr_i ? 16'd0 : cnt_q + 16'd1;
    end

    // Any 1->0 drop counts, including ones caused by DIV or TAC writes.
    assign tick  = tac_i[2] & cnt_q[tac_bit(tac_i[1:0])];
    assign inc_o = prev_q & ~tick;
    assign div_o = cnt_q[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 16'd0;
            prev_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= tick;
        end
    end

endmodule

// File: rtl/sm83_timer.sv
// DMG timer responder: DIV/TIMA/TMA/TAC registers, delayed TMA reload
// after TIMA overflow and the one-cycle timer interrupt pulse.
module sm83_timer
    import sm83_pkg::*;
#(
    parameter addr_t BASE_ADDR = 16'hFF04,
    parameter int    OVF_DELAY = 4
)
(
    input  logic  clk,
    input  logic  rst,
    input  addr_t addr,
    input  data_t w_data,
    input  logic  w_wen,
    output data_t r_data,
    output logic  hit,
    output logic  irq
);

    localparam int DLY_W = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(OVF_DELAY - 1);

    tmr_state_t       state_q, state_d;
    data_t            tima_q, tima_d;
    data_t            tma_q, tma_d;
    logic [2:0]       tac_q, tac_d;
    logic [DLY_W-1:0] dly_q, dly_d;

    addr_t      off;
    logic [1:0] sel;
    logic       wr, wr_div, wr_tima, wr_tma, wr_tac;
    data_t      div;
    logic       inc;
    logic [8:0] sum;

    assign off = addr - BASE_ADDR;
    assign hit = (off[15:2] == 14'd0);
    assign sel = off[1:0];

    assign wr      = w_wen & hit;
    assign wr_div  = wr & (sel == TMR_DIV);
    assign wr_tima = wr & (sel == TMR_TIMA);
    assign wr_tma  = wr & (sel == TMR_TMA);
    assign wr_tac  = wr & (sel == TMR_TAC);

    sm83_timer_tick u_tick (
        .clk       (clk),
        .rst       (rst),
        .div_clr_i (wr_div),
        .tac_i     (tac_q),
        .div_o     (div),
        .inc_o     (inc)
    );

    assign sum = {1'b0, tima_q} + 9'd1;

    always_comb begin
        tma_d = wr_tma ? w_data : tma_q;
        tac_d = wr_tac ? w_data[2:0] : tac_q;
    end

    always_comb begin
        state_d = state_q;
        tima_d  = tima_q;
        dly_d   = dly_q;
        unique case (state_q)
            RUN: begin
                if (wr_tima) begin
                    tima_d = w_data;
                end else if (inc) begin
                    if (sum[8]) begin
                        tima_d  = 8'h00;
                        dly_d   = DLY_INIT;
                        state_d = OVF;
                    end else begin
                        tima_d = sum[7:0];
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_d  = w_data;
                    state_d = RUN;
                end else if (dly_q == '0) begin
                    // Load on entry so TMA is visible alongside irq.
                    tima_d  = tma_q;
                    state_d = RELOAD;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            RELOAD: begin
                state_d = RUN;
                if (wr_tma) tima_d = w_data;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        irq = (state_q == RELOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            dly_q   <= dly_d;
        end
    end

    always_comb begin
        r_data = 8'h00;
        if (hit) begin
            unique case (sel)
                TMR_DIV:  r_data = div;
                TMR_TIMA: r_data = tima_q;
                TMR_TMA:  r_data = tma_q;
                TMR_TAC:  r_data = {5'b11111, tac_q};
                default:  r_data = 8'h00;
            endcase
        end
    end

endmodule

// File: doc/sm83_timer.md
Name: sm83_timer

Overview:
- Memory-mapped DMG timer and divider (DIV/TIMA/TMA/TAC).
- Responder on the sm83_core data bus, i.e. the target end of the core's addr/w_data/w_wen/r_data interface.
- Instantiated in sm83_top beside the ROM/WRAM responders; sm83_top muxes r_data using hit.
- Generates the timer interrupt request pulse for the future interrupt controller.

Parameters:
- BASE_ADDR, 16'hFF04: address of DIV; TIMA, TMA and TAC follow at +1, +2 and +3.
- OVF_DELAY, 4: number of clk cycles TIMA reads 8'h00 after overflow before the TMA reload.

Ports:
- clk  input  1  system clock; one clk equals one T-cycle.
- rst  input  1  asynchronous, active-high reset.
- addr  input  16 (addr_t)  bus address from the core.
- w_data  input  8 (data_t)  write data.
- w_wen  input  1  write strobe; a write is qualified by hit.
- r_data  output  8 (data_t)  read data; combinational from addr.
- hit  output  1  addr is in [BASE_ADDR, BASE_ADDR+3]; combinational.
- irq  output  1  timer interrupt request; one-cycle pulse.

Behaviour:
- Reset values:
  - Registers: sys_cnt=0, TIMA=0, TMA=0, TAC=0, prev_tick=0, state=RUN, dly_cnt=0.
  - Outputs: irq=0, r_data=8'h00 when hit=0.
- Reset is asynchronous and may be asserted mid-overflow. It aborts any pending reload, and no irq is issued.
- Reads (zero wait, same cycle as addr):
  - DIV = sys_cnt[15:8].
  - TIMA, TMA as stored.
  - TAC returns {5'b11111, TAC[2:0]}.
  - When hit=0, r_data=0.
- Writes (registered on the posedge where w_wen & hit):
  - DIV write: any data clears sys_cnt to 0.
  - TAC write: stores w_data[2:0].
  - TIMA and TMA writes: see the state machine below.
- sys_cnt: 16-bit free-running counter, +1 every clk, wraps FFFF→0000.
- Tick generation:
  - tick = TAC[2] & sys_cnt[b], where b is selected by TAC[1:0]: 00→bit 9, 01→bit 3, 10→bit 5, 11→bit 7.
  - prev_tick <= tick every cycle.
  - inc = prev_tick & ~tick (falling-edge detect).
  - Consequence: a DIV clear, TAC disable or TAC select change that drops tick from 1 to 0 produces one spurious increment. This is required DMG behaviour.
- State machine RUN / OVF / RELOAD:
  - RUN:
    - inc & TIMA≠FF: TIMA+1.
    - inc & TIMA=FF: TIMA<=00, dly_cnt<=OVF_DELAY-1, go to OVF.
    - A TIMA write has priority over inc in the same cycle (write wins, no increment).
  - OVF:
    - TIMA holds 00 and inc is discarded.
    - Each cycle dly_cnt decrements; at dly_cnt=0, go to RELOAD.
    - A TIMA write in OVF: TIMA<=w_data, go to RUN, reload and irq cancelled.
  - RELOAD (exactly one cycle):
    - TIMA<=TMA, irq=1 this cycle only, then go to RUN.
    - A TIMA write in this cycle is ignored.
    - A TMA write in this cycle updates TMA, and TIMA also takes w_data.
    - inc is discarded.
- Overflow timing: from the overflowing inc edge, TIMA reads 00 for OVF_DELAY cycles. On the following cycle TIMA shows TMA and irq is high.
- Width rules: TIMA arithmetic is 8-bit; overflow is detected via a 9-bit carry. No saturation.

Decomposition:
- sm83_pkg additions:
  - timer register offsets (TMR_DIV=0, TMR_TIMA=1, TMR_TMA=2, TMR_TAC=3);
  - tmr_state_t enum {RUN, OVF, RELOAD};
  - TAC select→bit lookup as a function.
- Reuse existing addr_t and data_t.
- One natural sub-module: sm83_timer_tick, containing sys_cnt, the TAC mux and the falling-edge detector, with output inc. The state machine and register file stay in sm83_timer.

Test Plan:
- Reset and readback:
  - Assert rst mid-count; read FF04..FF07 → 00, 00, 00, F8; irq=0.
  - Read FF08 → hit=0, r_data=00.
- DIV count and clear:
  - After 256 clks from reset, DIV reads 01; after 512 clks it reads 02.
  - Write 8'hAB to FF04 → DIV=00 on the next cycle.
- TIMA rate and overflow (TAC=05, i.e. bit 3, 16 clks/inc):
  - Write TMA=F0 and TIMA=FE; after 2 incs TIMA=00 for 4 cycles.
  - Then TIMA=F0 with irq high for exactly 1 cycle.
- Cancel in OVF: write TIMA=42 two cycles after overflow → TIMA=42, no irq, no reload.
- RELOAD-cycle write:
  - TMA=33 written in the RELOAD cycle → TIMA=33, TMA=33, irq=1.
  - TIMA=77 written in the RELOAD cycle → ignored, TIMA=TMA.
- Glitch increment: TAC=05 with sys_cnt[3]=1; write DIV → exactly one extra TIMA increment.
  - Repeat with TAC write to 01 (disable) → exactly one increment, none thereafter.
